// File: rtl/serial_pkg.sv
// Shared definitions for the bit-serial two's-complement path
// (word transmitter on one side, serial complementer on the other).
package serial_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } tx_state_e;

  localparam int unsigned DEFAULT_W = 8;

  // Both ends of the serial link agree on bit 0 travelling first.
  localparam bit LSB_FIRST = 1'b1;

  // Counter width for a 0..n-1 count, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bit_counter.sv
// Up-counter over 0..N-1 with synchronous clear; holds at N-1 rather than wrapping.
module bit_counter
  import serial_pkg::*;
#(
  parameter int unsigned N  = 8,
  parameter int unsigned CW = cnt_width(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          enable,
  output logic [CW-1:0] cnt,
  output logic          terminal
);

  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt      = cnt_q;
  assign terminal = (cnt_q == LAST);

endmodule

// File: rtl/serial_word_tx.sv
// Bit-serial word transmitter: valid/ready word in, LSB-first bit stream out
// with per-word start/last strobes and an optional idle gap between words.
module serial_word_tx
  import serial_pkg::*;
#(
  parameter int unsigned W   = DEFAULT_W,
  parameter int unsigned GAP = 0
) (
  input  logic         t_clk,
  input  logic         r,
  input  logic [W-1:0] din,
  input  logic         din_valid,
  output logic         din_ready,
  output logic         so,
  output logic         so_start,
  output logic         so_valid,
  output logic         so_last
);

  localparam int unsigned CW  = cnt_width(W);
  localparam int unsigned GN  = (GAP == 0) ? 1 : GAP;
  localparam int unsigned GCW = cnt_width(GN);
  localparam logic [CW-1:0] CNT_PENULT = CW'(W - 2);

  tx_state_e state_q, state_d;

  logic [W-1:0]   shreg_q, shreg_d;
  logic [W-1:0]   load_word;
  logic           so_q, so_d;
  logic           so_start_q, so_start_d;
  logic           so_valid_q, so_valid_d;
  logic           so_last_q, so_last_d;

  logic [CW-1:0]  cnt;
  logic           cnt_term;
  logic [GCW-1:0] gap_cnt_unused;
  logic           gap_term;
  logic           accept;
  logic           load;

  bit_counter #(.N(W)) u_bit_cnt (
    .clk      (t_clk),
    .rst      (r),
    .clear    (load || (state_q != ST_SHIFT)),
    .enable   (state_q == ST_SHIFT),
    .cnt      (cnt),
    .terminal (cnt_term)
  );

  bit_counter #(.N(GN)) u_gap_cnt (
    .clk      (t_clk),
    .rst      (r),
    .clear    (state_q != ST_GAP),
    .enable   (state_q == ST_GAP),
    .cnt      (gap_cnt_unused),
    .terminal (gap_term)
  );

  always_comb begin
    if (LSB_FIRST) begin
      load_word = din;
    end else begin
      load_word = {<<{din}};
    end
  end

  always_comb begin
    din_ready = 1'b0;
    if (!r) begin
      case (state_q)
        ST_IDLE:  din_ready = 1'b1;
        ST_SHIFT: din_ready = (GAP == 0) && cnt_term;
        default:  din_ready = 1'b0;
      endcase
    end
  end

  assign accept = din_valid && din_ready;

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_SHIFT;
          load    = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (cnt_term) begin
          if (GAP != 0) begin
            state_d = ST_GAP;
          end else if (accept) begin
            load = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_GAP: begin
        if (gap_term) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from next-cycle values so each strobe lines up
  // with the bit the shift register presents in that same cycle.
  always_comb begin
    shreg_d = shreg_q;
    if (load) begin
      shreg_d = load_word;
    end else if (state_q == ST_SHIFT) begin
      shreg_d = shreg_q >> 1;
    end
    so_valid_d = (state_d == ST_SHIFT);
    so_d       = so_valid_d && shreg_d[0];
    so_start_d = load;
    so_last_d  = (state_q == ST_SHIFT) && (cnt == CNT_PENULT);
  end

  always_ff @(posedge t_clk) begin
    if (r) begin
      state_q    <= ST_IDLE;
      shreg_q    <= '0;
      so_q       <= 1'b0;
      so_start_q <= 1'b0;
      so_valid_q <= 1'b0;
      so_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      so_q       <= so_d;
      so_start_q <= so_start_d;
      so_valid_q <= so_valid_d;
      so_last_q  <= so_last_d;
    end
  end

  assign so       = so_q;
  assign so_start = so_start_q;
  assign so_valid = so_valid_q;
  assign so_last  = so_last_q;

endmodule

// File: tb/tb_serial_word_tx.sv
// Bench for serial_word_tx: two instances (GAP=0 and GAP=2) share stimulus and
// are compared each cycle against a per-word timeline model and a serial negator.
module tb_serial_word_tx;

  localparam int unsigned W    = 8;
  localparam int          MAXC = 2048;

  logic         t_clk = 1'b0;
  logic         r = 1'b1;
  logic         din_valid = 1'b0;
  logic [W-1:0] din = '0;
  logic [1:0]   rdy, so, st, sv, sl;

  always #5 t_clk = ~t_clk;

  serial_word_tx #(.W(W), .GAP(0)) u_tx_gap0 (
    .t_clk     (t_clk),
    .r         (r),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (rdy[0]),
    .so        (so[0]),
    .so_start  (st[0]),
    .so_valid  (sv[0]),
    .so_last   (sl[0])
  );

  serial_word_tx #(.W(W), .GAP(2)) u_tx_gap2 (
    .t_clk     (t_clk),
    .r         (r),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (rdy[1]),
    .so        (so[1]),
    .so_start  (st[1]),
    .so_valid  (sv[1]),
    .so_last   (sl[1])
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int          cyc = 0;

  // Expected {last,start,valid,so} per instance per cycle, and the first
  // cycle each instance is ready for a new word.
  logic [3:0]   sched [2][MAXC];
  int           t_free [2];
  logic [W-1:0] words0 [$];
  logic [W-1:0] words1 [$];
  logic         cm_carry [2];
  logic [W-1:0] cm_acc [2];
  int           cm_idx [2];

  function automatic int gap_of(input int d);
    return (d == 0) ? 0 : 2;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic step(input logic r_v, input logic v_v, input logic [W-1:0] d_v,
                      input bit chk, output logic [1:0] acc);
    logic         exp_rdy;
    logic         have;
    logic [W-1:0] w;
    logic [W-1:0] neg;
    r         = r_v;
    din_valid = v_v;
    din       = d_v;
    acc       = '0;
    #1;
    for (int d = 0; d < 2; d++) begin
      exp_rdy = !r_v && (cyc >= t_free[d]);
      if (chk) begin
        check_eq((d == 0) ? "gap0 {rdy,last,start,valid,so}" : "gap2 {rdy,last,start,valid,so}",
                 32'({rdy[d], sl[d], st[d], sv[d], so[d]}),
                 32'({exp_rdy, sched[d][cyc]}));
        // Serial two's complement: pass bits up to the first 1, invert after.
        if (sv[d]) begin
          if (st[d]) begin
            cm_carry[d] = 1'b0;
            cm_acc[d]   = '0;
            cm_idx[d]   = 0;
          end
          if (cm_idx[d] < int'(W)) cm_acc[d][cm_idx[d]] = cm_carry[d] ? ~so[d] : so[d];
          if (so[d]) cm_carry[d] = 1'b1;
          cm_idx[d]++;
          if (sl[d]) begin
            have = (d == 0) ? (words0.size() > 0) : (words1.size() > 0);
            check_eq("cmpl word pending", 32'(have), 32'd1);
            if (have) begin
              w   = (d == 0) ? words0.pop_front() : words1.pop_front();
              neg = ~w + 1'b1;
              check_eq("cmpl result", 32'(cm_acc[d]), 32'(neg));
            end
          end
        end
      end
      if (r_v) begin
        for (int c = cyc + 1; c < MAXC; c++) sched[d][c] = '0;
        t_free[d] = cyc + 1;
        if (d == 0) words0.delete(); else words1.delete();
      end else if (v_v && exp_rdy) begin
        acc[d] = 1'b1;
        for (int k = 0; k < int'(W); k++)
          sched[d][cyc + 1 + k] = {k == int'(W) - 1, k == 0, 1'b1, d_v[k]};
        t_free[d] = (gap_of(d) == 0) ? cyc + int'(W) : cyc + int'(W) + gap_of(d) + 1;
        if (d == 0) words0.push_back(d_v); else words1.push_back(d_v);
      end
    end
    @(posedge t_clk);
    #2;
    cyc++;
  endtask

  initial begin
    logic [1:0]   acc;
    int           n0;
    int           n1;
    logic [W-1:0] cur;
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < MAXC; c++) sched[d][c] = '0;
      t_free[d]   = 0;
      cm_carry[d] = 1'b0;
      cm_acc[d]   = '0;
      cm_idx[d]   = 0;
    end

    // Reset held with din_valid high: outputs and din_ready stay 0.
    step(1'b1, 1'b1, 8'hB5, 1'b0, acc);
    step(1'b1, 1'b1, 8'hB5, 1'b1, acc);
    step(1'b1, 1'b1, 8'hB5, 1'b1, acc);

    // Single word 0xB5; din wanders afterwards and must be ignored.
    step(1'b0, 1'b1, 8'hB5, 1'b1, acc);
    repeat (14) step(1'b0, 1'b0, 8'($urandom), 1'b1, acc);

    // Back-to-back 0x01 then 0x80 with din_valid held.
    n0  = 0;
    n1  = 0;
    cur = 8'h01;
    for (int i = 0; i < 40 && (n0 < 2 || n1 < 2); i++) begin
      step(1'b0, 1'b1, cur, 1'b1, acc);
      n0 += int'(acc[0]);
      n1 += int'(acc[1]);
      if (acc != 2'b00) cur = 8'h80;
    end
    repeat (14) step(1'b0, 1'b0, 8'h55, 1'b1, acc);

    // Reset while bit 3 of 0xFF is on the line, then a fresh 0x0F.
    step(1'b0, 1'b1, 8'hFF, 1'b1, acc);
    repeat (3) step(1'b0, 1'b0, 8'hFF, 1'b1, acc);
    step(1'b1, 1'b0, 8'hFF, 1'b1, acc);
    step(1'b0, 1'b1, 8'h0F, 1'b1, acc);
    repeat (14) step(1'b0, 1'b0, 8'h00, 1'b1, acc);

    // End-to-end negation of 0x06.
    step(1'b0, 1'b1, 8'h06, 1'b1, acc);
    repeat (14) step(1'b0, 1'b0, 8'h00, 1'b1, acc);

    // Random traffic with backpressure, changing din and rare resets.
    repeat (400)
      step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, 8'($urandom), 1'b1, acc);
    repeat (20) step(1'b0, 1'b0, 8'h00, 1'b1, acc);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
